// File: rtl/axi_cmd_master.sv
// Single-outstanding AXI4 burst master: turns one command into an INCR burst
// and streams write/read data straight through to/from the AXI W/R channels.
module axi_cmd_master #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 16,
   parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
   parameter int                    ID_WIDTH   = 8,
   parameter logic [ID_WIDTH-1:0]   CMD_ID     = '0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_cmd_valid,
   input  logic                   i_cmd_write,
   input  logic [ADDR_WIDTH-1:0]  i_cmd_addr,
   input  logic [7:0]             i_cmd_len,
   output logic                   o_cmd_ready,
   input  logic [DATA_WIDTH-1:0]  i_wr_data,
   input  logic                   i_wr_valid,
   output logic                   o_wr_ready,
   output logic [DATA_WIDTH-1:0]  o_rd_data,
   output logic                   o_rd_last,
   output logic                   o_rd_valid,
   input  logic                   i_rd_ready,
   output logic                   o_done,
   output logic [1:0]             o_done_resp,
   output logic [ID_WIDTH-1:0]    o_m_axi_awid,
   output logic [ADDR_WIDTH-1:0]  o_m_axi_awaddr,
   output logic [7:0]             o_m_axi_awlen,
   output logic [2:0]             o_m_axi_awsize,
   output logic [1:0]             o_m_axi_awburst,
   output logic                   o_m_axi_awvalid,
   input  logic                   i_m_axi_awready,
   output logic [DATA_WIDTH-1:0]  o_m_axi_wdata,
   output logic [STRB_WIDTH-1:0]  o_m_axi_wstrb,
   output logic                   o_m_axi_wlast,
   output logic                   o_m_axi_wvalid,
   input  logic                   i_m_axi_wready,
   input  logic [ID_WIDTH-1:0]    i_m_axi_bid,
   input  logic [1:0]             i_m_axi_bresp,
   input  logic                   i_m_axi_bvalid,
   output logic                   o_m_axi_bready,
   output logic [ID_WIDTH-1:0]    o_m_axi_arid,
   output logic [ADDR_WIDTH-1:0]  o_m_axi_araddr,
   output logic [7:0]             o_m_axi_arlen,
   output logic [2:0]             o_m_axi_arsize,
   output logic [1:0]             o_m_axi_arburst,
   output logic                   o_m_axi_arvalid,
   input  logic                   i_m_axi_arready,
   input  logic [ID_WIDTH-1:0]    i_m_axi_rid,
   input  logic [DATA_WIDTH-1:0]  i_m_axi_rdata,
   input  logic [1:0]             i_m_axi_rresp,
   input  logic                   i_m_axi_rlast,
   input  logic                   i_m_axi_rvalid,
   output logic                   o_m_axi_rready
);

   localparam int LSB = $clog2(STRB_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

   typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R} state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [7:0]            r_len;
   logic [7:0]            r_cnt;
   logic [1:0]            r_acc;
   logic [1:0]            r_done_resp;
   logic                  r_cmd_ready;
   logic                  r_awvalid;
   logic                  r_arvalid;
   logic                  r_bready;
   logic                  r_done;

   logic                  w_in_w;
   logic                  w_in_r;
   logic                  w_wlast;
   logic                  w_w_hs;
   logic                  w_r_hs;
   logic [1:0]            w_acc_nxt;
   logic                  w_unused;

   assign w_in_w    = (r_state == S_W);
   assign w_in_r    = (r_state == S_R);
   assign w_wlast   = (r_cnt == r_len);
   assign w_w_hs    = w_in_w && i_wr_valid && i_m_axi_wready;
   assign w_r_hs    = w_in_r && i_m_axi_rvalid && i_rd_ready;
   assign w_acc_nxt = (i_m_axi_rresp > r_acc) ? i_m_axi_rresp : r_acc;
   assign w_unused  = ^{i_m_axi_bid, i_m_axi_rid};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_len       <= '0;
         r_cnt       <= '0;
         r_acc       <= '0;
         r_done_resp <= '0;
         r_cmd_ready <= 1'b0;
         r_awvalid   <= 1'b0;
         r_arvalid   <= 1'b0;
         r_bready    <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            // ready rises one cycle after arriving in IDLE, so never during done
            S_IDLE: begin
               r_cmd_ready <= 1'b1;
               if (i_cmd_valid && r_cmd_ready) begin
                  r_cmd_ready <= 1'b0;
                  r_addr      <= i_cmd_addr & ADDR_MASK;
                  r_len       <= i_cmd_len;
                  if (i_cmd_write) begin
                     r_state   <= S_AW;
                     r_awvalid <= 1'b1;
                  end else begin
                     r_state   <= S_AR;
                     r_arvalid <= 1'b1;
                     r_acc     <= '0;
                  end
               end
            end
            S_AW: if (i_m_axi_awready) begin
               r_awvalid <= 1'b0;
               r_cnt     <= '0;
               r_state   <= S_W;
            end
            S_W: if (w_w_hs) begin
               if (w_wlast) begin
                  r_state  <= S_B;
                  r_bready <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_B: if (i_m_axi_bvalid) begin
               r_bready    <= 1'b0;
               r_done      <= 1'b1;
               r_done_resp <= i_m_axi_bresp;
               r_state     <= S_IDLE;
            end
            S_AR: if (i_m_axi_arready) begin
               r_arvalid <= 1'b0;
               r_state   <= S_R;
            end
            S_R: if (w_r_hs) begin
               r_acc <= w_acc_nxt;
               if (i_m_axi_rlast) begin
                  r_done      <= 1'b1;
                  r_done_resp <= w_acc_nxt;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_cmd_ready     = r_cmd_ready;
   assign o_done          = r_done;
   assign o_done_resp     = r_done_resp;

   assign o_m_axi_awid    = CMD_ID;
   assign o_m_axi_awaddr  = r_addr;
   assign o_m_axi_awlen   = r_len;
   assign o_m_axi_awsize  = 3'(LSB);
   assign o_m_axi_awburst = 2'b01;
   assign o_m_axi_awvalid = r_awvalid;

   assign o_m_axi_wdata   = i_wr_data;
   assign o_m_axi_wstrb   = '1;
   assign o_m_axi_wlast   = w_in_w && w_wlast;
   assign o_m_axi_wvalid  = w_in_w && i_wr_valid;
   assign o_wr_ready      = w_in_w && i_m_axi_wready;
   assign o_m_axi_bready  = r_bready;

   assign o_m_axi_arid    = CMD_ID;
   assign o_m_axi_araddr  = r_addr;
   assign o_m_axi_arlen   = r_len;
   assign o_m_axi_arsize  = 3'(LSB);
   assign o_m_axi_arburst = 2'b01;
   assign o_m_axi_arvalid = r_arvalid;

   assign o_rd_data       = i_m_axi_rdata;
   assign o_rd_last       = w_in_r && i_m_axi_rlast;
   assign o_rd_valid      = w_in_r && i_m_axi_rvalid;
   assign o_m_axi_rready  = w_in_r && i_rd_ready;

endmodule

// File: tb/tb_axi_cmd_master.sv
// Bench for axi_cmd_master: a randomly-stalling AXI RAM slave, a flat word-array
// reference memory, and directed plus randomized write/read commands.
module tb_axi_cmd_master;

   localparam int         DW  = 32;
   localparam int         AW  = 16;
   localparam int         SW  = 4;
   localparam int         IW  = 8;
   localparam logic [7:0] CID = 8'h3C;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          cmd_valid = 1'b0, cmd_write = 1'b0, cmd_ready;
   logic [AW-1:0] cmd_addr = '0;
   logic [7:0]    cmd_len = '0;
   logic [DW-1:0] wr_data = '0, rd_data;
   logic          wr_valid = 1'b0, wr_ready;
   logic          rd_last, rd_valid, rd_ready = 1'b0;
   logic          done;
   logic [1:0]    done_resp;
   logic [IW-1:0] awid, arid, bid, rid;
   logic [AW-1:0] awaddr, araddr;
   logic [7:0]    awlen, arlen;
   logic [2:0]    awsize, arsize;
   logic [1:0]    awburst, arburst, bresp, rresp;
   logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rlast, rvalid, rready;
   logic [DW-1:0] wdata, rdata;
   logic [SW-1:0] wstrb;

   axi_cmd_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IW), .CMD_ID(CID)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_cmd_valid(cmd_valid), .i_cmd_write(cmd_write), .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len),
      .o_cmd_ready(cmd_ready),
      .i_wr_data(wr_data), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
      .o_rd_data(rd_data), .o_rd_last(rd_last), .o_rd_valid(rd_valid), .i_rd_ready(rd_ready),
      .o_done(done), .o_done_resp(done_resp),
      .o_m_axi_awid(awid), .o_m_axi_awaddr(awaddr), .o_m_axi_awlen(awlen), .o_m_axi_awsize(awsize),
      .o_m_axi_awburst(awburst), .o_m_axi_awvalid(awvalid), .i_m_axi_awready(awready),
      .o_m_axi_wdata(wdata), .o_m_axi_wstrb(wstrb), .o_m_axi_wlast(wlast), .o_m_axi_wvalid(wvalid),
      .i_m_axi_wready(wready),
      .i_m_axi_bid(bid), .i_m_axi_bresp(bresp), .i_m_axi_bvalid(bvalid), .o_m_axi_bready(bready),
      .o_m_axi_arid(arid), .o_m_axi_araddr(araddr), .o_m_axi_arlen(arlen), .o_m_axi_arsize(arsize),
      .o_m_axi_arburst(arburst), .o_m_axi_arvalid(arvalid), .i_m_axi_arready(arready),
      .i_m_axi_rid(rid), .i_m_axi_rdata(rdata), .i_m_axi_rresp(rresp), .i_m_axi_rlast(rlast),
      .i_m_axi_rvalid(rvalid), .o_m_axi_rready(rready)
   );

   // ---------------- AXI RAM slave (256 words, reset together with the DUT)
   logic [DW-1:0] slv_mem [256];
   logic [1:0]    rresp_tab [256];
   logic [1:0]    bresp_cfg = 2'b00;
   logic [7:0]    s_wbase, s_wbeat, s_rbase, s_rlen, s_rbeat;
   logic          s_bpend, s_ractive;
   wire  [7:0]    s_nb = s_rbeat + ((rvalid && rready) ? 8'd1 : 8'd0);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         awready <= 1'b0; wready <= 1'b0; arready <= 1'b0; bvalid <= 1'b0; rvalid <= 1'b0;
         bresp <= '0; bid <= '0; rid <= '0; rdata <= '0; rresp <= '0; rlast <= 1'b0;
         s_wbase <= '0; s_wbeat <= '0; s_rbase <= '0; s_rlen <= '0; s_rbeat <= '0;
         s_bpend <= 1'b0; s_ractive <= 1'b0;
         for (int i = 0; i < 256; i++) slv_mem[i] <= '0;
      end else begin
         awready <= ($urandom % 3) != 0;
         wready  <= ($urandom % 4) != 0;
         arready <= ($urandom % 3) != 0;
         if (awvalid && awready) begin s_wbase <= awaddr[9:2]; s_wbeat <= '0; end
         if (wvalid && wready) begin
            slv_mem[s_wbase + s_wbeat] <= wdata;
            s_wbeat <= s_wbeat + 8'd1;
            if (wlast) s_bpend <= 1'b1;
         end
         if (bvalid && bready) bvalid <= 1'b0;
         else if (s_bpend && !bvalid && ($urandom % 2) != 0) begin
            bvalid <= 1'b1; bresp <= bresp_cfg; bid <= IW'($urandom); s_bpend <= 1'b0;
         end
         if (arvalid && arready) begin
            s_rbase <= araddr[9:2]; s_rlen <= arlen; s_rbeat <= '0; s_ractive <= 1'b1;
         end
         if (rvalid && rready) begin
            s_rbeat <= s_rbeat + 8'd1;
            if (rlast) s_ractive <= 1'b0;
         end
         if (!rvalid || rready) begin
            if (s_ractive && !(rvalid && rlast) && ($urandom % 3) != 0) begin
               rvalid <= 1'b1;
               rdata  <= slv_mem[s_rbase + s_nb];
               rresp  <= rresp_tab[s_nb];
               rlast  <= (s_nb == s_rlen);
               rid    <= IW'($urandom);
            end else rvalid <= 1'b0;
         end
      end
   end

   // ---------------- monitors
   logic [AW-1:0] aw_addr_s, ar_addr_s;
   logic [7:0]    aw_len_s, ar_len_s, aw_id_s, ar_id_s;
   logic [2:0]    aw_size_s, ar_size_s;
   logic [1:0]    aw_burst_s, ar_burst_s;
   int            aw_cnt = 0, ar_cnt = 0, wlast_cnt = 0, wlast_idx = 0, strb_bad = 0, done_cnt = 0;
   logic [DW-1:0] w_q [$];
   logic [DW:0]   r_q [$];
   logic          rd_toggle = 1'b0;

   always @(posedge clk) begin
      if (awvalid && awready) begin
         aw_addr_s <= awaddr; aw_len_s <= awlen; aw_size_s <= awsize; aw_burst_s <= awburst;
         aw_id_s <= awid; aw_cnt <= aw_cnt + 1;
      end
      if (arvalid && arready) begin
         ar_addr_s <= araddr; ar_len_s <= arlen; ar_size_s <= arsize; ar_burst_s <= arburst;
         ar_id_s <= arid; ar_cnt <= ar_cnt + 1;
      end
      if (wvalid && wready) begin
         if (wlast) begin wlast_cnt <= wlast_cnt + 1; wlast_idx <= w_q.size(); end
         if (wstrb != '1) strb_bad <= strb_bad + 1;
         w_q.push_back(wdata);
      end
      if (rd_valid && rd_ready) r_q.push_back({rd_last, rd_data});
      if (done) done_cnt <= done_cnt + 1;
   end

   always @(negedge clk) rd_ready = rd_toggle ? !rd_ready : (($urandom % 4) != 0);

   // ---------------- reference model and checking
   logic [DW-1:0] ref_mem [256];
   int            checks = 0, errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_outs"}, {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rd_valid, wr_ready, done}, 0);
   endtask

   task automatic issue_cmd(input logic wr, input logic [AW-1:0] addr, input logic [7:0] len);
      int t = 0;
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
      while (!cmd_ready && t < 200) begin @(negedge clk); t++; end
      chk("cmd_accept_timeout", t < 200, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("cmd_ready_busy", cmd_ready, 0);
      chk("addr_valid_latency", wr ? awvalid : arvalid, 1);
   endtask

   task automatic wait_done(input logic [1:0] exp_resp);
      int t = 0;
      while (done !== 1'b1 && t < 3000) begin @(negedge clk); t++; end
      chk("done_timeout", t < 3000, 1);
      chk("done_resp", done_resp, exp_resp);
      chk("cmd_ready_in_done", cmd_ready, 0);
      @(negedge clk);
      chk("done_single_pulse", done, 0);
      chk("cmd_ready_after_done", cmd_ready, 1);
   endtask

   task automatic do_write(input logic [AW-1:0] addr, input logic [7:0] len, input bit rnd,
                           input logic [DW-1:0] dbase, input int stall_at, input int stall_n,
                           input int abort_at, input logic [1:0] br);
      logic [DW-1:0] data [$];
      int w0 = w_q.size(), aw0 = aw_cnt, wl0 = wlast_cnt, d0 = done_cnt;
      for (int i = 0; i <= int'(len); i++) data.push_back(rnd ? DW'($urandom) : dbase + DW'(i));
      bresp_cfg = br;
      issue_cmd(1'b1, addr, len);
      for (int i = 0; i <= int'(len); i++) begin
         int t = 0;
         if (i == stall_at) begin
            int ws = w_q.size();
            for (int k = 0; k < stall_n; k++) begin
               wr_valid = 1'b0;
               @(negedge clk);
               chk("stall_wvalid", wvalid, 0);
               chk("stall_no_beat", w_q.size(), ws);
               chk("stall_no_wlast", wlast, 0);
            end
         end
         wr_valid = 1'b1; wr_data = data[i];
         if (i == abort_at) begin
            rst_n = 1'b0;
            #1;
            chk_idle_outputs("abort");
            repeat (3) @(negedge clk);
            chk("abort_no_done", done_cnt, d0);
            wr_valid = 1'b0;
            rst_n = 1'b1;
            for (int j = 0; j < 256; j++) ref_mem[j] = '0;
            @(negedge clk);
            chk("cmd_ready_after_abort", cmd_ready, 1);
            return;
         end
         while (!wr_ready && t < 500) begin @(negedge clk); t++; end
         chk("wbeat_timeout", t < 500, 1);
         @(negedge clk);
      end
      wr_valid = 1'b0;
      wait_done(br);
      chk("aw_count", aw_cnt, aw0 + 1);
      chk("awaddr", aw_addr_s, addr & ~AW'(SW - 1));
      chk("awlen", aw_len_s, len);
      chk("awsize", aw_size_s, 2);
      chk("awburst", aw_burst_s, 1);
      chk("awid", aw_id_s, CID);
      chk("w_beats", w_q.size() - w0, int'(len) + 1);
      chk("wlast_count", wlast_cnt, wl0 + 1);
      chk("wlast_pos", wlast_idx, w0 + int'(len));
      for (int i = 0; i <= int'(len); i++) begin
         chk("wdata", w_q[w0 + i], data[i]);
         ref_mem[(int'(addr >> 2) + i) % 256] = data[i];
      end
   endtask

   task automatic do_read(input logic [AW-1:0] addr, input logic [7:0] len, input bit tog,
                          input bit rnd_resp, input logic [1:0] r0, input logic [1:0] r1,
                          input logic [1:0] r2);
      int q0 = r_q.size(), ar0 = ar_cnt;
      logic [1:0] worst = 2'b00;
      for (int i = 0; i <= int'(len); i++) begin
         if (rnd_resp) rresp_tab[i] = 2'($urandom);
         else rresp_tab[i] = (i == 0) ? r0 : (i == 1) ? r1 : (i == 2) ? r2 : 2'b00;
         if (rresp_tab[i] > worst) worst = rresp_tab[i];
      end
      rd_toggle = tog;
      issue_cmd(1'b0, addr, len);
      wait_done(worst);
      rd_toggle = 1'b0;
      chk("ar_count", ar_cnt, ar0 + 1);
      chk("araddr", ar_addr_s, addr & ~AW'(SW - 1));
      chk("arlen", ar_len_s, len);
      chk("arsize", ar_size_s, 2);
      chk("arburst", ar_burst_s, 1);
      chk("arid", ar_id_s, CID);
      chk("r_beats", r_q.size() - q0, int'(len) + 1);
      for (int i = 0; i <= int'(len) && q0 + i < r_q.size(); i++) begin
         chk("rd_data", r_q[q0 + i][DW-1:0], ref_mem[(int'(addr >> 2) + i) % 256]);
         chk("rd_last", r_q[q0 + i][DW], i == int'(len));
      end
   endtask

   initial begin
      for (int j = 0; j < 256; j++) begin ref_mem[j] = '0; rresp_tab[j] = '0; end
      repeat (3) @(negedge clk);
      chk_idle_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk("cmd_ready_first_clk", cmd_ready, 1);

      do_write(16'h0010, 8'd3, 1'b0, 32'hA0, -1, 0, -1, 2'b00);
      do_read(16'h0010, 8'd3, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
      do_write(16'h0007, 8'd0, 1'b1, 0, -1, 0, -1, 2'b00);
      do_read(16'h0004, 8'd0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
      do_write(16'h0040, 8'd5, 1'b1, 0, 2, 5, -1, 2'b00);
      do_read(16'h0040, 8'd2, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00);
      do_write(16'h0080, 8'd3, 1'b1, 0, -1, 0, -1, 2'b11);
      do_write(16'h0100, 8'd3, 1'b1, 0, -1, 0, 2, 2'b00);
      do_write(16'h0100, 8'd3, 1'b1, 0, -1, 0, -1, 2'b00);
      do_read(16'h0100, 8'd3, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);

      for (int n = 0; n < 24; n++) begin
         logic [AW-1:0] a = AW'($urandom_range(0, 16'h3FF));
         logic [7:0]    l = 8'($urandom_range(0, 7));
         if ($urandom % 2) do_write(a, l, 1'b1, 0, -1, 0, -1, 2'($urandom));
         else              do_read(a, l, 1'($urandom), 1'b1, 2'b00, 2'b00, 2'b00);
      end
      chk("wstrb_all_ones", strb_bad, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi_cmd_master.md
AXI_CMD_MASTER -- requirements
Module: axi_cmd_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: AXI data bus width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16: AXI byte address width.
REQ-003 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8: strobe width; must be a power of two.
REQ-004 SHALL have parameter ID_WIDTH, default 8: AXI ID width.
REQ-005 SHALL have parameter CMD_ID, default 0: constant driven on awid/arid.
REQ-006 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-008 SHALL have command inputs cmd_valid (1), cmd_write (1, 1=write), cmd_addr (ADDR_WIDTH, byte address), cmd_len (8, beats minus one), and output cmd_ready (1).
REQ-009 SHALL have write-data stream inputs wr_data (DATA_WIDTH) and wr_valid (1), and output wr_ready (1).
REQ-010 SHALL have read-data stream outputs rd_data (DATA_WIDTH), rd_last (1) and rd_valid (1), and input rd_ready (1).
REQ-011 SHALL have completion outputs done (1, one-cycle pulse) and done_resp (2, AXI response code).
REQ-012 SHALL have AXI AW master ports m_axi_awid/awaddr/awlen/awsize/awburst/awvalid out (ID_WIDTH/ADDR_WIDTH/8/3/2/1) and m_axi_awready in (1).
REQ-013 SHALL have AXI W master ports m_axi_wdata/wstrb/wlast/wvalid out (DATA_WIDTH/STRB_WIDTH/1/1) and m_axi_wready in.
REQ-014 SHALL have AXI B ports m_axi_bid (ID_WIDTH), bresp (2) and bvalid in, and m_axi_bready out.
REQ-015 SHALL have AXI AR master ports m_axi_arid/araddr/arlen/arsize/arburst/arvalid out and m_axi_arready in, with the same widths as AW.
REQ-016 SHALL have AXI R ports m_axi_rid/rdata/rresp/rlast/rvalid in (ID_WIDTH/DATA_WIDTH/2/1/1) and m_axi_rready out.

Function
REQ-017 SHALL implement FSM states IDLE, AW, W, B, AR, R; exactly one transaction outstanding.
REQ-018 SHALL drive cmd_ready=1 only in IDLE; on cmd_valid&&cmd_ready, it SHALL register addr/len and go to AW if cmd_write=1, else to AR.
REQ-019 SHALL drive awsize/arsize = log2(STRB_WIDTH), awburst/arburst = 2'b01 (INCR), awlen/arlen = registered cmd_len, and addr = registered cmd_addr with its low log2(STRB_WIDTH) bits forced to zero.
REQ-020 SHALL keep awvalid/arvalid high in AW/AR, with address fields stable, until the ready handshake; AW SHALL then go to W, and AR SHALL then go to R.
REQ-021 In W, it SHALL drive wvalid=wr_valid, wr_ready=wready, wdata=wr_data and wstrb all ones, combinationally, with no buffering.
REQ-022 In W, an 8-bit beat counter SHALL reset to 0 on entry and increment per W handshake; wlast=1 when counter==registered len; the wlast handshake SHALL move to B.
REQ-023 Outside W, wvalid and wr_ready SHALL be 0.
REQ-024 In B, it SHALL assert bready=1; on bvalid it SHALL pulse done=1 for one cycle with done_resp=bresp and return to IDLE.
REQ-025 In R, it SHALL drive rd_valid=rvalid, rd_data=rdata, rd_last=rlast and rready=rd_ready, combinationally.
REQ-026 In R, it SHALL accumulate the worst rresp seen: 2'b00 < 2'b01 < 2'b10 < 2'b11, compared numerically; the accumulator SHALL clear on AR entry.
REQ-027 On the rlast handshake, it SHALL pulse done with done_resp = the accumulator including that beat, and return to IDLE.
REQ-028 SHALL ignore bid/rid values.
REQ-029 The caller guarantees that a burst does not cross a 4 KB boundary; the block SHALL NOT check or split.
REQ-030 A new command SHALL be accepted no earlier than the cycle after done; command-to-AW/AR-valid latency SHALL be 1 cycle.
REQ-031 cmd_len=0 SHALL produce a single beat with wlast (or an expected rlast) on that beat.

Reset
REQ-032 While rst_n=0, state=IDLE, and cmd_ready, awvalid, wvalid, bready, arvalid, rready, rd_valid, wr_ready and done SHALL be 0; all registered fields, the counter and the accumulator SHALL be 0.
REQ-033 After rst_n deasserts, cmd_ready SHALL be 1 on the first rising clk.
REQ-034 Reset asserted mid-burst SHALL abort at once with no done pulse; the downstream slave is reset together with this block.

Verification
REQ-035 Write addr=0x0010, len=3, data 0xA0..0xA3 into the RAM slave -> AW 0x0010/len3/size2/INCR; 4 W beats, wlast on the 4th; done with resp=00.
REQ-036 Read back addr=0x0010, len=3 with rd_ready toggling 1/0 -> rd_data 0xA0..0xA3 in order, rd_last on 0xA3, no beat lost or duplicated, done resp=00.
REQ-037 Write len=0 at addr=0x0007 -> awaddr=0x0004, a single beat with wlast=1, done.
REQ-038 wr_valid held low for 5 cycles mid-burst -> wvalid low and counter frozen; the burst completes correctly when wr_valid resumes.
REQ-039 Slave returns rresp 00,10,00 on a 3-beat read -> done_resp=10.
REQ-040 rst_n pulsed low during W beat 2 -> all outputs 0 immediately, no done; after release, a new write command completes normally.
